count_sequencer: RTL and testbench

- Synchronous controller that sequences the team's small binary counter/clock-divider datapath: programmable prescaler plus WIDTH-bit up-counter with start/stop control, one-shot or free-running modes, and terminal-count reporting.
- Replaces ripple-clocked counting with a single-clock design driven by a clock enable (tick); downstream logic consumes count, tick, wrap and done.

---
 rtl/count_sequencer_if.sv | 26 ++
 rtl/count_sequencer.sv | 107 ++++++++++
 tb/tb_count_sequencer.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/count_sequencer_if.sv
// rtl/count_sequencer_if.sv - control and status bundle for count_sequencer
interface count_sequencer_if #(
    parameter int WIDTH = 2,
    parameter int DIV_W = 8
);
    logic             start;
    logic             stop;
    logic             mode;
    logic [DIV_W-1:0] div_sel;
    logic [WIDTH-1:0] limit;
    logic [WIDTH-1:0] count;
    logic             tick;
    logic             wrap;
    logic             done;
    logic             busy;

    modport master (
        output start, stop, mode, div_sel, limit,
        input  count, tick, wrap, done, busy
    );

    modport slave (
        input  start, stop, mode, div_sel, limit,
        output count, tick, wrap, done, busy
    );
endinterface

// File: rtl/count_sequencer.sv
// rtl/count_sequencer.sv - prescaled up-counter sequencer with one-shot/continuous modes
module count_sequencer #(
    parameter int WIDTH = 2,
    parameter int DIV_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    count_sequencer_if.slave   bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [DIV_W-1:0] presc_q, presc_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic             mode_q, mode_d;
    logic             tick_q, tick_d;
    logic             wrap_q, wrap_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            count_q <= '0;
            presc_q <= '0;
            div_q   <= '0;
            limit_q <= '0;
            mode_q  <= 1'b0;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            presc_q <= presc_d;
            div_q   <= div_d;
            limit_q <= limit_d;
            mode_q  <= mode_d;
            tick_q  <= tick_d;
            wrap_q  <= wrap_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        presc_d = presc_q;
        div_d   = div_q;
        limit_d = limit_q;
        mode_d  = mode_q;
        tick_d  = 1'b0;
        wrap_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.stop) begin
                    state_d = S_RUN;
                    count_d = '0;
                    presc_d = '0;
                    div_d   = bus.div_sel;
                    limit_d = bus.limit;
                    mode_d  = bus.mode;
                end
            end
            S_RUN: begin
                // stop takes priority over a count event on the same edge
                if (bus.stop) begin
                    state_d = S_IDLE;
                end else if (presc_q == div_q) begin
                    presc_d = '0;
                    tick_d  = 1'b1;
                    if (count_q != limit_q) begin
                        count_d = count_q + 1'b1;
                    end else if (mode_q) begin
                        count_d = '0;
                        wrap_d  = 1'b1;
                    end else begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_RUN);
    end

    assign bus.count = count_q;
    assign bus.tick  = tick_q;
    assign bus.wrap  = wrap_q;
    assign bus.done  = done_q;
    assign bus.busy  = busy_q;
endmodule

// File: tb/tb_count_sequencer.sv
// tb/tb_count_sequencer.sv - randomized self-checking bench for count_sequencer
module tb_count_sequencer;
    localparam int WIDTH = 2;
    localparam int DIV_W = 8;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    count_sequencer_if #(.WIDTH(WIDTH), .DIV_W(DIV_W)) bus ();

    count_sequencer #(.WIDTH(WIDTH), .DIV_W(DIV_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // reference: run progress tracked as elapsed cycles since start
    int m_state;   // 0 idle, 1 running, 2 finished
    int m_count;
    int m_elapsed;
    int m_div;
    int m_lim;
    int m_mode;
    int m_tick;
    int m_wrap;
    int m_done;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_count = 0; m_elapsed = 0;
        m_div = 0; m_lim = 0; m_mode = 0;
        m_tick = 0; m_wrap = 0; m_done = 0;
    endtask

    task automatic model_edge();
        m_tick = 0; m_wrap = 0; m_done = 0;
        if (m_state == 1) begin
            if (bus.stop) begin
                m_state = 0;
            end else begin
                m_elapsed++;
                if (m_elapsed % (m_div + 1) == 0) begin
                    m_tick = 1;
                    if (m_count == m_lim) begin
                        if (m_mode != 0) begin
                            m_count = 0;
                            m_wrap  = 1;
                        end else begin
                            m_done  = 1;
                            m_state = 2;
                        end
                    end else begin
                        m_count++;
                    end
                end
            end
        end else if (m_state == 2) begin
            m_state = 0;
        end else if (bus.start && !bus.stop) begin
            m_state   = 1;
            m_count   = 0;
            m_elapsed = 0;
            m_div     = int'(bus.div_sel);
            m_lim     = int'(bus.limit);
            m_mode    = int'(bus.mode);
        end
    endtask

    task automatic check_outputs();
        check("count", int'(bus.count), m_count);
        check("tick",  int'(bus.tick),  m_tick);
        check("wrap",  int'(bus.wrap),  m_wrap);
        check("done",  int'(bus.done),  m_done);
        check("busy",  int'(bus.busy),  (m_state == 1) ? 1 : 0);
    endtask

    task automatic drive(input bit st, input bit sp, input bit md, input int dv, input int lm);
        bus.start   = st;
        bus.stop    = sp;
        bus.mode    = md;
        bus.div_sel = DIV_W'(dv);
        bus.limit   = WIDTH'(lm);
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_edge();
            #1;
            check_outputs();
        end
    endtask

    initial begin
        rst = 1'b0;
        drive(0, 0, 0, 0, 0);
        model_reset();
        #12;
        check_outputs();
        @(negedge clk);
        rst = 1'b1;

        // continuous, tick every cycle
        drive(1, 0, 1, 0, 3); step(1);
        drive(0, 0, 1, 0, 3); step(10);
        drive(0, 1, 0, 0, 0); step(2);

        // one-shot, period 3, limit 2
        drive(1, 0, 0, 2, 2); step(1);
        drive(0, 0, 0, 0, 0); step(14);

        // stop on the edge where a count event would occur
        drive(1, 0, 1, 1, 3); step(1);
        drive(0, 0, 0, 0, 0); step(3);
        drive(0, 1, 0, 0, 0); step(1);
        drive(0, 0, 0, 0, 0); step(2);
        drive(1, 1, 1, 0, 3); step(1);
        drive(0, 0, 0, 0, 0); step(2);

        // limit zero, both modes
        drive(1, 0, 0, 4, 0); step(1);
        drive(0, 0, 0, 0, 0); step(8);
        drive(1, 0, 1, 4, 0); step(1);
        drive(0, 0, 0, 0, 0); step(16);
        drive(0, 1, 0, 0, 0); step(1);

        // inputs changed mid-run must not affect the latched run
        drive(1, 0, 1, 1, 3); step(1);
        drive(1, 0, 0, 5, 1); step(12);
        drive(0, 1, 0, 5, 1); step(1);
        drive(1, 0, 1, 5, 1); step(1);
        drive(0, 0, 0, 0, 0); step(14);
        drive(0, 1, 0, 0, 0); step(1);

        // asynchronous reset mid-run
        drive(1, 0, 1, 3, 3); step(1);
        drive(0, 0, 0, 0, 0); step(6);
        #1 rst = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk); #1;
        check_outputs();
        @(negedge clk);
        rst = 1'b1;
        step(3);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom % 4) == 0, ($urandom % 20) == 0, $urandom % 2,
                  $urandom_range(0, 5), $urandom_range(0, 3));
            step(1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
